csa_accum_sequencer: RTL and testbench
======================================

# csa_accum_sequencer

Sequencer that feeds the 12-input carry-save reduction tree in the FP multiplier datapath. It collects up to 12 48-bit partial-product words from an upstream valid/ready stream and holds them stable on the tree inputs. It waits out the tree's register latency, then resolves the tree's sum/carry pair with a final carry-propagate add. The resolved 48-bit result is presented on a downstream valid/ready port, one result per group.

## Interface
- `N_TERMS`, 12: words per group; equals the tree fan-in.
- `WIDTH`, 48: word and result width.
- `CSA_LAT`, 1: cycles from tree-input change to valid `csa_sum`/`csa_carry` (tree input register stage).

- `clk`  in  1  clock; all state updates on the rising edge.
- `nreset`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  sequencer accepts a word this cycle.
- `in_data`  in  WIDTH  partial-product word.
- `in_last`  in  1  qualifies `in_data`; this word closes the group early.
- `csa_product`  out  WIDTH x N_TERMS (unpacked `[0:N_TERMS-1]`)  bank driving the tree inputs.
- `csa_sum`  in  WIDTH  tree sum vector.
- `csa_carry`  in  WIDTH  tree carry vector, already bit-aligned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  resolved group sum, modulo 2^WIDTH.
- `out_count`  out  4  number of words in the group, 1..N_TERMS.
- `busy`  out  1  high in WAIT and OUT.

## Operation
- **States:**
  - FILL: `in_ready`=1.
  - WAIT: latency countdown.
  - OUT: `out_valid`=1.
- **Reset values:**
  - Reset state is FILL.
  - Bank all-zero, slot counter 0, `out_data`=0, `out_count`=0, `out_valid`=0, `busy`=0.
  - `in_ready`=1 follows the reset state.
- **FILL:**
  - Each accepted word (`in_valid`&`in_ready`) is written to `bank[slot]` and the slot counter increments.
  - When the accept occurs with slot==N_TERMS-1 or `in_last`=1: go to WAIT, load the wait counter with CSA_LAT, latch `out_count`=slot+1.
- **Slot filling:**
  - Slots never written in a group remain zero, so early-closed groups sum correctly.
  - `in_last` on the 12th word is equivalent to a full group.
- **WAIT:**
  - `in_ready`=0; the bank is frozen.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0, `out_data` <= `csa_sum` + `csa_carry` (truncated to WIDTH) and the state goes to OUT.
  - WAIT lasts CSA_LAT+1 cycles.
- **OUT:**
  - `out_valid`=1; `out_data`/`out_count` are held stable until `out_ready`.
  - On `out_valid`&`out_ready`: clear the bank and slot counter, go to FILL.
  - The first word of the next group can be accepted in the cycle after the handshake; there is no same-cycle turnaround.
- **Handshakes:**
  - `in_valid`/`out_ready` are sampled only in their owning states.
  - `in_data` is ignored when `in_ready`=0.
  - `out_valid` never drops without a handshake.
- **Reset mid-operation:** asynchronous reset from any state returns to FILL immediately and discards the partial group and any pending result.

## Timing
- Word accepted closing the group at edge of cycle T:
  - bank stable from cycle T+1;
  - `out_valid` first high in cycle T+CSA_LAT+2 (T+3 at default).
- Full-group throughput at default: 12 fill + 2 wait + at least 1 out = 15 cycles per result.
- `in_ready`, `out_valid`, `busy` are decoded from registered state only; there is no combinational path from `in_valid`/`out_ready` to outputs.
- `csa_product` is driven directly from bank registers.

## Configuration
- `CSA_SEQ_BYPASS_EN`:
  - **Defined:** a group whose first accepted word has `in_last`=1 skips WAIT. `out_data` <= `in_data`, `out_count`=1, state goes to OUT, and `out_valid` is high in cycle T+1. The bank is not written.
  - **Undefined:** single-word groups take the normal tree path with T+CSA_LAT+2 latency. The result value is identical in both builds.

## Test plan
- **Full group:** 12 words 1..12 back-to-back, `out_ready`=1 -> `out_data`=78, `out_count`=12, `out_valid` 3 cycles after the 12th accept, `in_ready` low for exactly 3 cycles.
- **Early close:** words 0xFFFF_FFFF_FFFF, 1, 2 with `in_last` on the 3rd -> `out_data`=2 (mod 2^48 wrap), `out_count`=3; slots 3..11 observed zero on `csa_product`.
- **Backpressure:** `out_ready`=0 for 10 cycles after `out_valid` -> `out_data` stable, `in_ready`=0 throughout; the next group's first word is accepted the cycle after the handshake.
- **Bubbles:** `in_valid` toggled 1/0 over a 12-word group of 0x800000000000 each -> `out_data`=0 (wrap), no word lost or duplicated.
- **Mid-operation reset:** `nreset` pulsed low in WAIT after 5 words -> `out_valid`=0, `busy`=0, bank zero immediately. A following 2-word group of 7, 9 yields 16.
- **Bypass:** single word 0x123 with `in_last` -> `out_data`=0x123; `out_valid` at T+1 with `CSA_SEQ_BYPASS_EN`, T+3 without.

Source files
------------

// File: rtl/csa_accum_sequencer.sv
// Collects up to N_TERMS partial-product words onto the carry-save tree inputs, waits out the tree latency,
// then resolves sum+carry into one result per group. Optional single-word bypass: CSA_SEQ_BYPASS_EN.
module csa_accum_sequencer #(
    parameter int N_TERMS = 12,
    parameter int WIDTH   = 48,
    parameter int CSA_LAT = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] csa_product [0:N_TERMS-1],
    input  logic [WIDTH-1:0] csa_sum,
    input  logic [WIDTH-1:0] csa_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_count,
    output logic             busy
);

    localparam int CW = (CSA_LAT < 1) ? 1 : $clog2(CSA_LAT + 1);
    localparam logic [3:0] LAST_SLOT = 4'(N_TERMS - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bank_q [0:N_TERMS-1];
    logic [WIDTH-1:0] bank_d [0:N_TERMS-1];
    logic [3:0]       slot_q, slot_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]       out_count_q, out_count_d;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        slot_d      = slot_q;
        wait_d      = wait_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
`ifdef CSA_SEQ_BYPASS_EN
                    // A lone word needs no tree reduction: forward it and leave the bank untouched.
                    if (in_last && slot_q == 4'd0) begin
                        out_data_d  = in_data;
                        out_count_d = 4'd1;
                        state_d     = ST_OUT;
                    end else
`endif
                    begin
                        bank_d[slot_q] = in_data;
                        slot_d         = slot_q + 4'd1;
                        if (in_last || slot_q == LAST_SLOT) begin
                            state_d     = ST_WAIT;
                            wait_d      = CW'(CSA_LAT);
                            out_count_d = slot_q + 4'd1;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    out_data_d = csa_sum + csa_carry;
                    state_d    = ST_OUT;
                end else begin
                    wait_d = wait_q - CW'(1);
                end
            end
            ST_OUT: begin
                // Unused slots must be zero for the next early-closed group to sum correctly.
                if (out_ready) begin
                    for (int i = 0; i < N_TERMS; i++) begin
                        bank_d[i] = '0;
                    end
                    slot_d  = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_FILL;
            for (int i = 0; i < N_TERMS; i++) begin
                bank_q[i] <= '0;
            end
            slot_q      <= '0;
            wait_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            slot_q      <= slot_d;
            wait_q      <= wait_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign csa_product = bank_q;
    assign in_ready    = (state_q == ST_FILL);
    assign out_valid   = (state_q == ST_OUT);
    assign busy        = (state_q != ST_FILL);
    assign out_data    = out_data_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Scoreboard bench for csa_accum_sequencer with a registered stand-in for the carry-save tree.
// Honours CSA_SEQ_BYPASS_EN to select the expected single-word latency.
module tb_csa_accum_sequencer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        in_last;
    logic [47:0] csa_product [0:11];
    logic [47:0] csa_sum;
    logic [47:0] csa_carry;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic [3:0]  out_count;
    logic        busy;

    typedef struct {
        logic [47:0] d;
        logic [3:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef CSA_SEQ_BYPASS_EN
    localparam int BYP_LAT = 1;
`else
    localparam int BYP_LAT = 3;
`endif

    csa_accum_sequencer #(.N_TERMS(12), .WIDTH(48), .CSA_LAT(1)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .csa_product(csa_product),
        .csa_sum    (csa_sum),
        .csa_carry  (csa_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Tree stand-in: one register stage, total split so the final add really matters.
    logic [47:0] tree_total;
    always_comb begin
        tree_total = '0;
        for (int i = 0; i < 12; i++) tree_total = tree_total + csa_product[i];
    end

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            csa_sum   <= '0;
            csa_carry <= '0;
        end else begin
            csa_carry <= tree_total & 48'h0000_00FF_FF0F;
            csa_sum   <= tree_total - (tree_total & 48'h0000_00FF_FF0F);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is pending whenever valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (nreset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result actual=%0h required=none", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", {16'h0, out_data}, {16'h0, e.d});
                checkOutput("out_count", {60'h0, out_count}, {60'h0, e.c});
            end
        end
    end

    task automatic applyStimulus(input logic [47:0] d, input logic last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic measure(output int first_valid, output int low_cnt);
        first_valid = 0;
        low_cnt     = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid && first_valid == 0) first_valid = n;
            if (in_ready) break;
            low_cnt++;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] bankOr(input int lo);
        logic [47:0] r;
        r = '0;
        for (int i = lo; i < 12; i++) r = r | csa_product[i];
        return r;
    endfunction

    initial begin
        int fv;
        int lc;
        int n;
        logic [47:0] held;
        logic        stable;

        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("reset_in_ready", {63'h0, in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'h0, out_valid}, 64'd0);
        checkOutput("reset_busy", {63'h0, busy}, 64'd0);
        checkOutput("reset_out_data", {16'h0, out_data}, 64'd0);
        checkOutput("reset_out_count", {60'h0, out_count}, 64'd0);
        checkOutput("reset_bank", {16'h0, bankOr(0)}, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Full group 1..12
        $display("[TB] full group");
        for (int i = 1; i <= 12; i++) begin
            if (i == 12) exp_q.push_back('{d: 48'd78, c: 4'd12});
            applyStimulus(48'(i), 1'b0);
        end
        measure(fv, lc);
        checkOutput("full_latency", 64'(fv), 64'd3);
        checkOutput("full_ready_low", 64'(lc), 64'd3);
        waitDrain();

        // Early close with wrap
        $display("[TB] early close");
        exp_q.push_back('{d: 48'd2, c: 4'd3});
        applyStimulus(48'hFFFF_FFFF_FFFF, 1'b0);
        applyStimulus(48'd1, 1'b0);
        applyStimulus(48'd2, 1'b1);
        @(negedge clk);
        checkOutput("early_slot0", {16'h0, csa_product[0]}, 64'hFFFF_FFFF_FFFF);
        checkOutput("early_slot2", {16'h0, csa_product[2]}, 64'd2);
        checkOutput("early_unused_zero", {16'h0, bankOr(3)}, 64'd0);
        waitDrain();

        // Backpressure
        $display("[TB] backpressure");
        out_ready = 1'b0;
        exp_q.push_back('{d: 48'd11, c: 4'd2});
        applyStimulus(48'd5, 1'b0);
        applyStimulus(48'd6, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("bp_valid_seen", {63'h0, out_valid}, 64'd1);
        held   = out_data;
        stable = 1'b1;
        in_valid = 1'b1;
        in_data  = 48'd100;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        checkOutput("bp_held_stable", {63'h0, stable}, 64'd1);
        exp_q.push_back('{d: 48'd100, c: 4'd1});
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_no_same_cycle_ready", {63'h0, in_ready}, 64'd0);
        @(negedge clk);
        checkOutput("bp_ready_after_hs", {63'h0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        waitDrain();

        // Bubbles
        $display("[TB] bubbles");
        for (int i = 0; i < 12; i++) begin
            if (i == 11) exp_q.push_back('{d: 48'd0, c: 4'd12});
            applyStimulus(48'h8000_0000_0000, 1'b0);
            @(posedge clk);
            #1;
        end
        waitDrain();

        // Reset in WAIT
        $display("[TB] mid reset");
        for (int i = 0; i < 5; i++) applyStimulus(48'(i + 3), i == 4);
        checkOutput("mid_busy_before", {63'h0, busy}, 64'd1);
        nreset = 1'b0;
        #1;
        checkOutput("mid_out_valid", {63'h0, out_valid}, 64'd0);
        checkOutput("mid_busy", {63'h0, busy}, 64'd0);
        checkOutput("mid_in_ready", {63'h0, in_ready}, 64'd1);
        checkOutput("mid_bank_zero", {16'h0, bankOr(0)}, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{d: 48'd16, c: 4'd2});
        applyStimulus(48'd7, 1'b0);
        applyStimulus(48'd9, 1'b1);
        waitDrain();

        // Single-word group
        $display("[TB] single word");
        exp_q.push_back('{d: 48'h123, c: 4'd1});
        applyStimulus(48'h123, 1'b1);
        checkOutput("single_bank0", {16'h0, csa_product[0]}, (BYP_LAT == 1) ? 64'h0 : 64'h123);
        measure(fv, lc);
        checkOutput("single_latency", 64'(fv), 64'(BYP_LAT));
        waitDrain();

        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
